// File: rtl/cpu_irq_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : cpu_irq_sequencer
//  Description : Bridges a PLIC register bus to a single-level core interrupt.
//                Claims the pending source, presents it to the core, and
//                writes the completion back once the handler is done. It also
//                reprograms the PLIC enable register on request.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_irq_sequencer #(
  parameter logic [23:0] CLAIM_ADDR  = 24'h200004,
  parameter logic [23:0] ENABLE_ADDR = 24'h002000,
  parameter int unsigned TIMEOUT     = 64
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_plic_interrupt,
  output logic        o_bus_request,
  output logic        o_bus_rw,
  output logic [23:0] o_bus_address,
  output logic [31:0] o_bus_wdata,
  input  logic [31:0] i_bus_rdata,
  input  logic        i_bus_ready,
  input  logic        i_enable_valid,
  input  logic [3:0]  i_enable_mask,
  output logic        o_irq,
  output logic [2:0]  o_irq_id,
  input  logic        i_irq_ack,
  input  logic        i_irq_done,
  output logic        o_busy,
  output logic        o_bus_error,
  output logic [7:0]  o_spurious_count
);

  localparam int unsigned    CNT_W        = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [2:0]     MAX_ID       = 3'd4;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    CFG_WR      = 3'd1,
    CLAIM_RD    = 3'd2,
    PRESENT     = 3'd3,
    IN_SERVICE  = 3'd4,
    COMPLETE_WR = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic              req_q, req_d;
  logic              rw_q, rw_d;
  logic [23:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              irq_q, irq_d;
  logic [2:0]        id_q, id_d;
  logic              err_q, err_d;
  logic [7:0]        spur_q, spur_d;
  logic              cfg_pend_q, cfg_pend_d;
  logic [3:0]        cfg_mask_q, cfg_mask_d;
  // Set when a new mask arrives while the previous one is on the bus, so the
  // buffer stays pending after the in-flight write completes.
  logic              cfg_redo_q, cfg_redo_d;

  logic              w_bus_done;
  logic              w_bus_timeout;
  logic              w_cfg_any;
  logic [3:0]        w_cfg_mask;
  logic [2:0]        w_claim_id;
  logic              w_unused_rdata;

  assign w_bus_done     = req_q & i_bus_ready;
  assign w_bus_timeout  = req_q & ~i_bus_ready & (cnt_q == TIMEOUT_LAST);
  // A config pulse arriving in IDLE is honoured in the same cycle so that it
  // beats a simultaneous interrupt.
  assign w_cfg_any      = cfg_pend_q | i_enable_valid;
  assign w_cfg_mask     = i_enable_valid ? i_enable_mask : cfg_mask_q;
  assign w_claim_id     = i_bus_rdata[2:0];
  assign w_unused_rdata = ^i_bus_rdata[31:3];

  // State and output registers; reset returns everything to idle and empty.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      rw_q       <= 1'b0;
      addr_q     <= 24'h0;
      wdata_q    <= 32'h0;
      cnt_q      <= '0;
      irq_q      <= 1'b0;
      id_q       <= 3'd0;
      err_q      <= 1'b0;
      spur_q     <= 8'h0;
      cfg_pend_q <= 1'b0;
      cfg_mask_q <= 4'h0;
      cfg_redo_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      irq_q      <= irq_d;
      id_q       <= id_d;
      err_q      <= err_d;
      spur_q     <= spur_d;
      cfg_pend_q <= cfg_pend_d;
      cfg_mask_q <= cfg_mask_d;
      cfg_redo_q <= cfg_redo_d;
    end
  end

  // Next-state, bus sequencing and config-buffer update.
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    rw_d       = rw_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    irq_d      = irq_q;
    id_d       = id_q;
    err_d      = err_q;
    spur_d     = spur_q;
    cfg_pend_d = cfg_pend_q;
    cfg_mask_d = cfg_mask_q;
    cfg_redo_d = cfg_redo_q;

    // Wait-cycle count of the in-flight transaction.
    if (req_q && !i_bus_ready) begin
      cnt_d = cnt_q + 1'b1;
    end

    // A finished or abandoned transaction drops request and parks the bus.
    if (w_bus_done || w_bus_timeout) begin
      req_d   = 1'b0;
      rw_d    = 1'b0;
      addr_d  = 24'h0;
      wdata_d = 32'h0;
      cnt_d   = '0;
    end

    if (w_bus_timeout) begin
      err_d   = 1'b1;
      state_d = IDLE;
      irq_d   = 1'b0;
      id_d    = 3'd0;
    end

    case (state_q)
      IDLE: begin
        // Request is launched on the transition, so IDLE always provides the
        // idle bus cycle between back-to-back transactions.
        if (w_cfg_any) begin
          state_d    = CFG_WR;
          req_d      = 1'b1;
          rw_d       = 1'b1;
          addr_d     = ENABLE_ADDR;
          wdata_d    = {27'b0, w_cfg_mask, 1'b0};
          cnt_d      = '0;
          cfg_redo_d = 1'b0;
        end else if (i_plic_interrupt) begin
          state_d = CLAIM_RD;
          req_d   = 1'b1;
          rw_d    = 1'b0;
          addr_d  = CLAIM_ADDR;
          wdata_d = 32'h0;
          cnt_d   = '0;
        end
      end

      CFG_WR: begin
        if (w_bus_done) begin
          state_d    = IDLE;
          cfg_pend_d = cfg_redo_q;
        end
      end

      CLAIM_RD: begin
        if (w_bus_done) begin
          // Id 0 means nothing was pending; ids beyond the last source cannot
          // be a real claim and are counted the same way.
          if (w_claim_id == 3'd0 || w_claim_id > MAX_ID) begin
            state_d = IDLE;
            if (spur_q != 8'hFF) begin
              spur_d = spur_q + 8'd1;
            end
          end else begin
            state_d = PRESENT;
            irq_d   = 1'b1;
            id_d    = w_claim_id;
          end
        end
      end

      PRESENT: begin
        if (i_irq_done) begin
          state_d = COMPLETE_WR;
          irq_d   = 1'b0;
          req_d   = 1'b1;
          rw_d    = 1'b1;
          addr_d  = CLAIM_ADDR;
          wdata_d = {29'b0, id_q};
          cnt_d   = '0;
        end else if (i_irq_ack) begin
          state_d = IN_SERVICE;
          irq_d   = 1'b0;
        end
      end

      IN_SERVICE: begin
        if (i_irq_done) begin
          state_d = COMPLETE_WR;
          req_d   = 1'b1;
          rw_d    = 1'b1;
          addr_d  = CLAIM_ADDR;
          wdata_d = {29'b0, id_q};
          cnt_d   = '0;
        end
      end

      COMPLETE_WR: begin
        if (w_bus_done) begin
          state_d = IDLE;
          id_d    = 3'd0;
        end
      end

      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
        irq_d   = 1'b0;
        id_d    = 3'd0;
      end
    endcase

    // Enable requests are accepted in every state; the newest mask wins.
    if (i_enable_valid) begin
      cfg_mask_d = i_enable_mask;
      cfg_pend_d = 1'b1;
      if (state_q == CFG_WR) begin
        cfg_redo_d = 1'b1;
      end
    end
  end

  assign o_bus_request    = req_q;
  assign o_bus_rw         = rw_q;
  assign o_bus_address    = addr_q;
  assign o_bus_wdata      = wdata_q;
  assign o_irq            = irq_q;
  assign o_irq_id         = id_q;
  assign o_busy           = (state_q != IDLE);
  assign o_bus_error      = err_q;
  assign o_spurious_count = spur_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_irq_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_cpu_irq_sequencer
//  Description : Scoreboard bench for cpu_irq_sequencer. Expected bus
//                transactions and interrupt ids are queued by the stimulus;
//                monitors pop and compare when the DUT presents them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_irq_sequencer;

  localparam logic [23:0] CLAIM  = 24'h200004;
  localparam logic [23:0] ENABLE = 24'h002000;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_plic_interrupt = 1'b0;
  logic        o_bus_request, o_bus_rw;
  logic [23:0] o_bus_address;
  logic [31:0] o_bus_wdata;
  logic [31:0] i_bus_rdata = 32'h0;
  logic        i_bus_ready = 1'b0;
  logic        i_enable_valid = 1'b0;
  logic [3:0]  i_enable_mask = 4'h0;
  logic        o_irq;
  logic [2:0]  o_irq_id;
  logic        i_irq_ack = 1'b0, i_irq_done = 1'b0;
  logic        o_busy, o_bus_error;
  logic [7:0]  o_spurious_count;

  int errors = 0;
  int checks = 0;
  logic        hold_ready = 1'b0;
  logic        irq_prev   = 1'b0;
  logic [56:0] bus_q[$];
  logic [2:0]  irq_q[$];

  cpu_irq_sequencer #(
    .CLAIM_ADDR (CLAIM),
    .ENABLE_ADDR(ENABLE),
    .TIMEOUT    (64)
  ) dut (
    .i_clock         (clk),
    .i_reset         (i_reset),
    .i_plic_interrupt(i_plic_interrupt),
    .o_bus_request   (o_bus_request),
    .o_bus_rw        (o_bus_rw),
    .o_bus_address   (o_bus_address),
    .o_bus_wdata     (o_bus_wdata),
    .i_bus_rdata     (i_bus_rdata),
    .i_bus_ready     (i_bus_ready),
    .i_enable_valid  (i_enable_valid),
    .i_enable_mask   (i_enable_mask),
    .o_irq           (o_irq),
    .o_irq_id        (o_irq_id),
    .i_irq_ack       (i_irq_ack),
    .i_irq_done      (i_irq_done),
    .o_busy          (o_busy),
    .o_bus_error     (o_bus_error),
    .o_spurious_count(o_spurious_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bus slave and transaction monitor: one-cycle ready unless held off.
  always @(negedge clk) begin
    if (o_bus_request && !hold_ready) begin
      i_bus_ready = 1'b1;
      if (bus_q.size() == 0) begin
        chk("bus_unexpected", {7'b0, o_bus_rw, o_bus_address, o_bus_wdata}, 64'h1FFFFFFFFFFFFFF);
      end else begin
        chk("bus_txn", {7'b0, o_bus_rw, o_bus_address, o_bus_wdata}, {7'b0, bus_q.pop_front()});
      end
    end else begin
      i_bus_ready = 1'b0;
    end
  end

  // Interrupt monitor: each rising o_irq must match the next queued id.
  always @(negedge clk) begin
    if (o_irq && !irq_prev) begin
      if (irq_q.size() == 0) chk("irq_unexpected", {61'b0, o_irq_id}, 64'hFF);
      else                   chk("irq_id", {61'b0, o_irq_id}, {61'b0, irq_q.pop_front()});
    end
    irq_prev = o_irq;
  end

  task automatic wait_idle(input string name);
    logic ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (bus_q.size() == 0 && !o_busy && !o_bus_request) ok = 1'b1;
    end
    chk(name, {63'b0, ok}, 64'd1);
  endtask

  task automatic wait_irq(input string name, output int lat);
    lat = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      lat++;
      if (o_irq) break;
    end
    chk(name, {63'b0, o_irq}, 64'd1);
  endtask

  task automatic pulse_cfg(input logic [3:0] mask);
    i_enable_valid = 1'b1;
    i_enable_mask  = mask;
    @(negedge clk);
    i_enable_valid = 1'b0;
  endtask

  task automatic pulse_done();
    i_irq_done = 1'b1;
    @(negedge clk);
    i_irq_done = 1'b0;
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int lat;
    int n;
    logic saw_req;

    // Reset state
    repeat (3) @(negedge clk);
    i_reset = 1'b0;
    @(negedge clk);
    chk("rst_request", {63'b0, o_bus_request}, 0);
    chk("rst_irq", {60'b0, o_irq, o_irq_id}, 0);
    chk("rst_busy_err", {62'b0, o_busy, o_bus_error}, 0);
    chk("rst_spurious", {56'b0, o_spurious_count}, 0);

    // Enable reprogramming, mask 1010 -> wdata 0x14
    bus_q.push_back({1'b1, ENABLE, 32'h14});
    pulse_cfg(4'b1010);
    wait_idle("cfg_idle");
    chk("cfg_req_low", {63'b0, o_bus_request}, 0);

    // Normal claim of id 2, ack then done
    i_bus_rdata = 32'd2;
    bus_q.push_back({1'b0, CLAIM, 32'h0});
    irq_q.push_back(3'd2);
    @(negedge clk);
    i_plic_interrupt = 1'b1;
    wait_irq("irq2_seen", lat);
    i_plic_interrupt = 1'b0;
    chk("irq2_latency_le4", {63'b0, (lat <= 4)}, 1);
    chk("irq2_id_out", {61'b0, o_irq_id}, 2);
    bus_q.push_back({1'b1, CLAIM, 32'h2});
    i_irq_ack = 1'b1;
    @(negedge clk);
    i_irq_ack = 1'b0;
    chk("ack_irq_low", {63'b0, o_irq}, 0);
    chk("ack_busy", {63'b0, o_busy}, 1);
    repeat (3) @(negedge clk);
    chk("in_service_no_req", {63'b0, o_bus_request}, 0);
    pulse_done();
    wait_idle("complete_idle");
    chk("complete_busy", {63'b0, o_busy}, 0);
    chk("complete_id_zero", {61'b0, o_irq_id}, 0);

    // Spurious claim
    i_bus_rdata = 32'd0;
    bus_q.push_back({1'b0, CLAIM, 32'h0});
    i_plic_interrupt = 1'b1;
    @(negedge clk);
    i_plic_interrupt = 1'b0;
    wait_idle("spur_idle");
    chk("spur_count", {56'b0, o_spurious_count}, 1);
    chk("spur_no_irq", {63'b0, o_irq}, 0);

    // Config and interrupt together, then config during service
    i_bus_rdata = 32'd3;
    bus_q.push_back({1'b1, ENABLE, 32'h0A});
    bus_q.push_back({1'b0, CLAIM, 32'h0});
    irq_q.push_back(3'd3);
    i_plic_interrupt = 1'b1;
    pulse_cfg(4'b0101);
    chk("prio_cfg_first", {63'b0, o_bus_rw}, 1);
    wait_irq("irq3_seen", lat);
    i_plic_interrupt = 1'b0;
    i_irq_ack = 1'b1;
    @(negedge clk);
    i_irq_ack = 1'b0;
    pulse_cfg(4'b0011);
    repeat (2) @(negedge clk);
    chk("cfg_deferred", {62'b0, o_bus_request, o_busy}, 1);
    bus_q.push_back({1'b1, CLAIM, 32'h3});
    bus_q.push_back({1'b1, ENABLE, 32'h06});
    pulse_done();
    wait_idle("deferred_idle");

    // Claim read that never gets ready
    hold_ready = 1'b1;
    i_bus_rdata = 32'd1;
    i_plic_interrupt = 1'b1;
    @(negedge clk);
    i_plic_interrupt = 1'b0;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      if (o_bus_request) n++;
      else if (n > 0) break;
      @(negedge clk);
    end
    hold_ready = 1'b0;
    chk("timeout_req_cycles", n, 64);
    chk("timeout_error", {63'b0, o_bus_error}, 1);
    chk("timeout_idle", {62'b0, o_busy, o_irq}, 0);
    bus_q.push_back({1'b1, ENABLE, 32'h1E});
    pulse_cfg(4'b1111);
    wait_idle("post_timeout_idle");
    chk("error_sticky", {63'b0, o_bus_error}, 1);

    // Reset during completion write
    i_bus_rdata = 32'd4;
    bus_q.push_back({1'b0, CLAIM, 32'h0});
    irq_q.push_back(3'd4);
    i_plic_interrupt = 1'b1;
    wait_irq("irq4_seen", lat);
    i_plic_interrupt = 1'b0;
    hold_ready = 1'b1;
    pulse_done();
    @(negedge clk);
    chk("cw_req_pending", {63'b0, o_bus_request}, 1);
    i_reset = 1'b1;
    @(negedge clk);
    i_reset = 1'b0;
    hold_ready = 1'b0;
    chk("rst2_bus", {7'b0, o_bus_request, o_bus_rw, o_bus_address, o_bus_wdata}, 0);
    chk("rst2_irq", {60'b0, o_irq, o_irq_id}, 0);
    chk("rst2_status", {54'b0, o_busy, o_bus_error, o_spurious_count}, 0);
    saw_req = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (o_bus_request) saw_req = 1'b1;
    end
    chk("rst2_no_completion", {63'b0, saw_req}, 0);

    chk("bus_queue_drained", bus_q.size(), 0);
    chk("irq_queue_drained", irq_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cpu_irq_sequencer.md
CPU_IRQ_SEQUENCER -- requirements
Module: cpu_irq_sequencer

Interface
REQ-001 Parameter CLAIM_ADDR, 24'h200004, PLIC claim/complete register address.
REQ-002 Parameter ENABLE_ADDR, 24'h002000, PLIC enable register address.
REQ-003 Parameter TIMEOUT, 64, max cycles to wait for i_bus_ready per transaction.
REQ-004 Port: i_clock  in  1  single clock; all logic on posedge.
REQ-005 Port: i_reset  in  1  synchronous, active-high reset.
REQ-006 Port: i_plic_interrupt  in  1  PLIC any-pending level.
REQ-007 Ports: o_bus_request out 1, o_bus_rw out 1 (1=write), o_bus_address out 24, o_bus_wdata out 32  PLIC register-bus master outputs.
REQ-008 Ports: i_bus_rdata in 32, i_bus_ready in 1  PLIC bus responses.
REQ-009 Ports: i_enable_valid in 1 (pulse), i_enable_mask in 4  enable-reprogramming request.
REQ-010 Ports: o_irq out 1, o_irq_id out 3  interrupt presented to core.
REQ-011 Ports: i_irq_ack in 1, i_irq_done in 1  core took trap / finished handler.
REQ-012 Ports: o_busy out 1, o_bus_error out 1 (sticky), o_spurious_count out 8.

Function
REQ-013 States SHALL be IDLE, CFG_WR, CLAIM_RD, PRESENT, IN_SERVICE, COMPLETE_WR.
REQ-014 Bus: request, rw, address, wdata registered, stable while request high; request SHALL drop at the edge sampling i_bus_ready=1; at least one idle cycle between transactions.
REQ-015 IDLE: pending config SHALL win over i_plic_interrupt=1; config -> CFG_WR, else interrupt -> CLAIM_RD.
REQ-016 i_enable_valid in any state SHALL latch mask into a one-deep buffer (last write wins, pending flag set).
REQ-017 CFG_WR: write ENABLE_ADDR, wdata = {27'b0, mask, 1'b0}; pending flag cleared on ready; -> IDLE.
REQ-018 CLAIM_RD: read CLAIM_ADDR; on ready capture i_bus_rdata[2:0] as id.
REQ-019 Claim id 0 SHALL be spurious: o_spurious_count += 1 (saturate 255), -> IDLE, no o_irq.
REQ-020 Claim id 1..4 -> PRESENT; o_irq=1, o_irq_id=id, registered, asserted first cycle of PRESENT.
REQ-021 PRESENT: i_irq_ack -> IN_SERVICE with o_irq=0; i_irq_done (with or without ack) -> COMPLETE_WR directly.
REQ-022 IN_SERVICE: wait for i_irq_done; i_irq_ack ignored; no nesting, new interrupts wait.
REQ-023 COMPLETE_WR: write CLAIM_ADDR, wdata = {29'b0, id}; on ready -> IDLE, o_irq_id=0.
REQ-024 Per-transaction cycle counter; reaching TIMEOUT without ready SHALL drop request, set o_bus_error, -> IDLE (claim context discarded).
REQ-025 o_bus_error SHALL clear only on reset.
REQ-026 o_busy = 1 in every state except IDLE.
REQ-027 Latency: i_plic_interrupt rise in IDLE to o_irq ≤ 4 cycles with 1-cycle ready.

Reset
REQ-028 i_reset SHALL force IDLE from any state, mid-transaction included, next edge.
REQ-029 Reset values: all outputs 0, config buffer empty, counters 0.
REQ-030 After reset, sequencer SHALL NOT issue a completion write for a claim interrupted by reset.

Verification
REQ-031 i_enable_valid, mask=4'b1010 -> one write, addr 24'h002000, wdata 32'h14; request low after ready.
REQ-032 Interrupt, claim rdata=2 -> o_irq=1, id=2; ack then done -> write addr 24'h200004, wdata 32'h2; o_busy 0.
REQ-033 Interrupt, claim rdata=0 -> no o_irq, o_spurious_count=1, IDLE.
REQ-034 Interrupt and i_enable_valid same cycle -> CFG_WR first, then claim; config pulse during IN_SERVICE serviced after completion.
REQ-035 Ready held low 64 cycles during CLAIM_RD -> request drops, o_bus_error=1, IDLE; stays set until reset.
REQ-036 Reset asserted in COMPLETE_WR before ready -> next cycle all outputs 0, no further bus request.
